// File: rtl/alias_pkg.sv
// Shared types and constants for the alias_sequencer datapath.
// Optional feature macro: ALIAS_HOLD_EN (zero-order hold of discarded samples).
package alias_pkg;

  localparam int SAMPLE_W_DEF = 32;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    PROC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // One-hot decimation codes; all-zero means pass-through.
  localparam logic [2:0] RATIO_1 = 3'b000;
  localparam logic [2:0] RATIO_2 = 3'b001;
  localparam logic [2:0] RATIO_4 = 3'b010;
  localparam logic [2:0] RATIO_8 = 3'b100;

  // Maps a raw selector onto a legal ratio code; unknown codes mean 1:1.
  function automatic logic [2:0] decode_ratio(input logic [2:0] sel);
    case (sel)
      RATIO_2: return RATIO_2;
      RATIO_4: return RATIO_4;
      RATIO_8: return RATIO_8;
      default: return RATIO_1;
    endcase
  endfunction

endpackage

// File: rtl/alias_ratio_decode.sv
// Combinational keep/discard decision for the current sample phase.
// Optional feature macro (used by the top only): ALIAS_HOLD_EN.
module alias_ratio_decode
  import alias_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [2:0]       ratio_active,
  input  logic [CNT_W-1:0] counter_val,
  output logic             keep
);

  logic [CNT_W-1:0] w_mask;

  // A sample is kept when the phase bits below the ratio are all zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_mask unassigned (no latch).
    w_mask = '0;
    case (ratio_active)
      RATIO_2: w_mask = CNT_W'(1);
      RATIO_4: w_mask = CNT_W'(3);
      RATIO_8: w_mask = CNT_W'(7);
      default: w_mask = '0;
    endcase
  end

  assign keep = ((counter_val & w_mask) == '0);

endmodule

// File: rtl/alias_sequencer.sv
// Audio alias sequencer: FIFO handshake, sample phase counter, decimation
// with frame-aligned ratio changes.
// Optional feature macro: ALIAS_HOLD_EN -- discarded samples repeat the last
// kept sample instead of being zeroed.
module alias_sequencer
  import alias_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                audio_in_available,
  input  logic                audio_out_allowed,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  input  logic [2:0]          ratio_sel,
  output logic                read_audio_in,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [CNT_W-1:0]    counter_val,
  output logic [2:0]          ratio_active
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_read;
  logic                r_write;
  logic [SAMPLE_W-1:0] r_cap_l, r_cap_r;
  logic [SAMPLE_W-1:0] r_out_l, r_out_r;
  logic [SAMPLE_W-1:0] w_drop_l, w_drop_r;
  logic [CNT_W-1:0]    r_counter;
  logic [2:0]          r_shadow;
  logic [2:0]          r_active;
  logic                w_keep;
  logic                w_write_fire;
  logic                w_wrap;

  alias_ratio_decode #(.CNT_W(CNT_W)) u_decode (
    .ratio_active (r_active),
    .counter_val  (r_counter),
    .keep         (w_keep)
  );

  assign w_write_fire = (r_state == WRITE) && audio_out_allowed;
  assign w_wrap       = w_write_fire && (r_counter == CNT_MAX);

  // Next-state logic for the IDLE/READ/PROC/WRITE handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (audio_in_available && audio_out_allowed) w_next_state = READ;
      READ:    w_next_state = PROC;
      PROC:    w_next_state = WRITE;
      WRITE:   if (audio_out_allowed) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register plus registered FIFO strobes; write follows the accepting WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      r_read  <= (w_next_state == READ);
      r_write <= w_write_fire;
    end
  end

  // Capture both channels while the input FIFO is being popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_l <= '0;
      r_cap_r <= '0;
    end else if (r_state == READ) begin
      r_cap_l <= left_channel_audio_in;
      r_cap_r <= right_channel_audio_in;
    end
  end

`ifdef ALIAS_HOLD_EN
  logic [SAMPLE_W-1:0] r_hold_l, r_hold_r;

  // Remember the most recent kept sample for zero-order hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (r_state == PROC && w_keep) begin
      r_hold_l <= r_cap_l;
      r_hold_r <= r_cap_r;
    end
  end

  assign w_drop_l = r_hold_l;
  assign w_drop_r = r_hold_r;
`else
  assign w_drop_l = '0;
  assign w_drop_r = '0;
`endif

  // Load the output registers once per sample, kept or discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_l <= '0;
      r_out_r <= '0;
    end else if (r_state == PROC) begin
      r_out_l <= w_keep ? r_cap_l : w_drop_l;
      r_out_r <= w_keep ? r_cap_r : w_drop_r;
    end
  end

  // Shadow the selector every cycle; phase advances and ratio switches only on writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= RATIO_1;
      r_active  <= RATIO_1;
      r_counter <= '0;
    end else begin
      r_shadow <= decode_ratio(ratio_sel);
      if (w_write_fire) r_counter <= r_counter + CNT_ONE;
      if (w_wrap)       r_active  <= r_shadow;
    end
  end

  assign read_audio_in           = r_read;
  assign write_audio_out         = r_write;
  assign left_channel_audio_out  = r_out_l;
  assign right_channel_audio_out = r_out_r;
  assign counter_val             = r_counter;
  assign ratio_active            = r_active;

endmodule

// File: tb/tb_alias_sequencer.sv
// Self-checking bench for alias_sequencer with a transaction-level model.
// Build with +define+ALIAS_HOLD_EN to check the zero-order-hold variant.
module tb_alias_sequencer;

  localparam int SW = 32;
  localparam int CW = 4;
  localparam int FRAME = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          avail = 1'b0;
  logic          allowed = 1'b0;
  logic [SW-1:0] left_in = '0, right_in = '0;
  logic [2:0]    ratio_sel = 3'b000;
  logic          read_audio_in, write_audio_out;
  logic [SW-1:0] left_out, right_out;
  logic [CW-1:0] counter_val;
  logic [2:0]    ratio_active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_read_cyc = -100;

  // Model state: phase within frame, applied ratio, last kept sample.
  int          m_phase  = 0;
  logic [2:0]  m_active = 3'b000;
  logic [SW-1:0] m_hold_l = '0, m_hold_r = '0;

  alias_sequencer #(.SAMPLE_W(SW), .CNT_W(CW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .audio_in_available      (avail),
    .audio_out_allowed       (allowed),
    .left_channel_audio_in   (left_in),
    .right_channel_audio_in  (right_in),
    .ratio_sel               (ratio_sel),
    .read_audio_in           (read_audio_in),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .counter_val             (counter_val),
    .ratio_active            (ratio_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sel_to_ratio(input logic [2:0] sel);
    if (sel == 3'b001 || sel == 3'b010 || sel == 3'b100) return sel;
    return 3'b000;
  endfunction

  function automatic int ratio_n(input logic [2:0] act);
    case (act)
      3'b001:  return 2;
      3'b010:  return 4;
      3'b100:  return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_active = 3'b000;
    m_hold_l = '0;
    m_hold_r = '0;
  endtask

  // One full sample transaction, checked at every observable step.
  task automatic do_sample(input logic [SW-1:0] l, input logic [SW-1:0] r,
                           input int stall, input bit drop, input bit chk_period);
    int waited;
    bit keep;
    logic [SW-1:0] exp_l, exp_r;
    left_in  = l;
    right_in = r;
    avail    = 1'b1;
    allowed  = 1'b1;
    waited   = 0;
    while (read_audio_in !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      check("read_timeout", 64'd0, 64'd1);
      return;
    end
    if (chk_period) check("read_period", 64'(cyc - last_read_cyc), 64'd4);
    last_read_cyc = cyc;
    check("rd_counter", 64'(counter_val), 64'(m_phase));
    check("rd_ratio", 64'(ratio_active), 64'(m_active));
    check("rd_wr_excl", 64'(write_audio_out), 64'd0);

    keep = (m_phase % ratio_n(m_active)) == 0;
`ifdef ALIAS_HOLD_EN
    exp_l = keep ? l : m_hold_l;
    exp_r = keep ? r : m_hold_r;
`else
    exp_l = keep ? l : '0;
    exp_r = keep ? r : '0;
`endif
    if (keep) begin
      m_hold_l = l;
      m_hold_r = r;
    end

    if (drop) avail = 1'b0;
    if (stall > 0) allowed = 1'b0;
    @(negedge clk);  // PROC
    if (drop) begin
      left_in  = ~l;
      right_in = ~r;
    end
    @(negedge clk);  // WRITE
    check("out_left", 64'(left_out), 64'(exp_l));
    check("out_right", 64'(right_out), 64'(exp_r));
    check("no_early_write", 64'(write_audio_out), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_no_write", 64'(write_audio_out), 64'd0);
      check("stall_hold_left", 64'(left_out), 64'(exp_l));
    end
    allowed = 1'b1;
    @(negedge clk);
    check("write_pulse", 64'(write_audio_out), 64'd1);
    check("wr_rd_excl", 64'(read_audio_in), 64'd0);
    check("wr_counter", 64'(counter_val), 64'((m_phase + 1) % FRAME));

    m_phase = (m_phase + 1) % FRAME;
    if (m_phase == 0) m_active = sel_to_ratio(ratio_sel);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"}, 64'(read_audio_in), 64'd0);
    check({tag, "_write"}, 64'(write_audio_out), 64'd0);
    check({tag, "_left"}, 64'(left_out), 64'd0);
    check({tag, "_right"}, 64'(right_out), 64'd0);
    check({tag, "_counter"}, 64'(counter_val), 64'd0);
    check({tag, "_ratio"}, 64'(ratio_active), 64'd0);
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // Pass-through with constant data, crossing a frame wrap.
    ratio_sel = 3'b000;
    for (int i = 0; i < 20; i++) do_sample(32'h1234, 32'h5678, 0, 1'b0, i > 0);

    // 4:1 selected from reset: first frame is still 1:1, second applies 4:1.
    reset_n = 1'b0;
    ratio_sel = 3'b010;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) do_sample(SW'(i), SW'(i), 0, 1'b0, 1'b0);

    // Mid-frame change 001 -> 100 takes effect only at the next wrap.
    ratio_sel = 3'b001;
    for (int i = 0; i < FRAME; i++) do_sample($urandom, $urandom, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 5) ratio_sel = 3'b100;
      do_sample($urandom, $urandom, 0, 1'b0, 1'b0);
    end

    // Invalid selector during a frame, then 2:1 for the directed 10/20/30/40 run.
    ratio_sel = 3'b111;
    for (int i = 0; i < 8; i++) do_sample($urandom, $urandom, 0, 1'b0, 1'b0);
    ratio_sel = 3'b001;
    while (m_phase != 0) do_sample($urandom, $urandom, 0, 1'b0, 1'b0);
    do_sample(32'd10, 32'd10, 0, 1'b0, 1'b0);
    do_sample(32'd20, 32'd20, 0, 1'b0, 1'b0);
    do_sample(32'd30, 32'd30, 0, 1'b0, 1'b0);
    do_sample(32'd40, 32'd40, 0, 1'b0, 1'b0);

    // Output backpressure for 10 cycles during WRITE.
    do_sample($urandom, $urandom, 10, 1'b0, 1'b0);
    do_sample($urandom, $urandom, 10, 1'b0, 1'b0);

    // Input availability dropping after READ, inputs scrambled after capture.
    do_sample($urandom, $urandom, 0, 1'b1, 1'b0);
    do_sample($urandom, $urandom, 3, 1'b1, 1'b0);

    // Asynchronous reset during PROC.
    left_in  = 32'hDEAD_BEEF;
    right_in = 32'hCAFE_F00D;
    avail    = 1'b1;
    allowed  = 1'b1;
    begin
      int waited = 0;
      while (read_audio_in !== 1'b1 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) check("prst_read_timeout", 64'd0, 64'd1);
    end
    @(negedge clk);  // PROC
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) do_sample($urandom, $urandom, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
